// File: rtl/transposition_tile_sequencer_if.sv
// Stream bundle around the transposition tile sequencer.
//   in_row/in_valid/in_ready : upstream tile rows, valid/ready handshake
//   out_row/out_valid/out_last : transposed rows to the systolic multiplier,
//                                valid-qualified, no backpressure
// slave  : the sequencer side (consumes in_*, produces out_*)
// master : the environment side (produces in_*, consumes out_*)
interface transposition_tile_sequencer_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int SYSTOLIC_WIDTH = 4
);
  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] in_row;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] out_row;
  logic                                 out_valid;
  logic                                 out_last;

  modport master (
    output in_row, in_valid,
    input  in_ready, out_row, out_valid, out_last
  );

  modport slave (
    input  in_row, in_valid,
    output in_ready, out_row, out_valid, out_last
  );
endinterface

// File: rtl/transposition_tile_sequencer.sv
// Buffers one W x W tile arriving row by row, then drives the transposition
// array for W load cycles and W read cycles, capturing the array's output
// rows into a registered valid-qualified stream.
//   clk    : single clock, rising edge
//   rst    : synchronous, active-high reset
//   strm   : in_row/in_valid/in_ready and out_row/out_valid/out_last
//   tr_in  : row to the array's matrix input (combinational)
//   tr_mode: array mode, 0 = load, 1 = read out (combinational)
//   tr_out : array's output row
//   busy   : high while loading or reading the array
module transposition_tile_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int SYSTOLIC_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  transposition_tile_sequencer_if.slave        strm,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] tr_in,
  output logic                                 tr_mode,
  input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] tr_out,
  output logic                                 busy
);

  localparam int RW = SYSTOLIC_WIDTH * DATA_WIDTH;
  localparam int CW = $clog2(SYSTOLIC_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(SYSTOLIC_WIDTH - 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   tile_buf [SYSTOLIC_WIDTH];
  logic [RW-1:0]   out_row_q;
  logic            out_valid_q;
  logic            out_last_q;

  // Tile buffer is not reset; a reset returns to FILL, so stale rows are
  // always overwritten by W fresh handshakes before they are ever driven.
  always_ff @(posedge clk) begin
    if (state == FILL && strm.in_valid) begin
      tile_buf[cnt] <= strm.in_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      cnt         <= '0;
      out_row_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      case (state)
        FILL: begin
          if (strm.in_valid) begin
            if (cnt == LAST) begin
              state <= LOAD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        LOAD: begin
          if (cnt == LAST) begin
            state <= READ;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READ: begin
          out_row_q   <= tr_out;
          out_valid_q <= 1'b1;
          out_last_q  <= (cnt == LAST);
          if (cnt == LAST) begin
            state <= FILL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= FILL;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Array controls are decoded combinationally so the array registers the
  // row on the same edge that advances cnt.
  always_comb begin
    tr_in = '0;
    if (state == LOAD) begin
      tr_in = tile_buf[cnt];
    end
  end

  assign tr_mode        = (state == READ);
  assign busy           = (state != FILL);
  assign strm.in_ready  = (state == FILL);
  assign strm.out_row   = out_row_q;
  assign strm.out_valid = out_valid_q;
  assign strm.out_last  = out_last_q;

endmodule

// File: tb/tb_transposition_tile_sequencer.sv
// Self-checking bench for transposition_tile_sequencer (W=4, DW=16).
// A behavioural transposition array (shift-in rows, read out columns) or a
// counter stub drives tr_out; expected output rows are the transpose of the
// fed tile, or the stub values recorded during each read cycle.
module tb_transposition_tile_sequencer;

  localparam int DW = 16;
  localparam int W  = 4;
  localparam int RW = W * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] tr_in;
  logic          tr_mode;
  logic [RW-1:0] tr_out;
  logic          busy;

  transposition_tile_sequencer_if #(.DATA_WIDTH(DW), .SYSTOLIC_WIDTH(W)) bus ();

  transposition_tile_sequencer #(.DATA_WIDTH(DW), .SYSTOLIC_WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .strm    (bus.slave),
    .tr_in   (tr_in),
    .tr_mode (tr_mode),
    .tr_out  (tr_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural array: rows shift in while in load mode, columns come out
  // one per cycle in read mode.
  logic [RW-1:0] mat [W];
  int            rd = 0;
  logic [RW-1:0] arr_out;
  logic [RW-1:0] stub_val;
  bit            use_stub = 1'b0;

  always @(posedge clk) begin
    if (!tr_mode) begin
      for (int i = 0; i < W - 1; i++) mat[i] <= mat[i+1];
      mat[W-1] <= tr_in;
      rd <= 0;
    end else begin
      rd <= (rd + 1) % W;
    end
  end

  always_comb begin
    for (int j = 0; j < W; j++) arr_out[j*DW +: DW] = mat[j][rd*DW +: DW];
  end

  always @(posedge clk) begin
    for (int j = 0; j < W; j++) stub_val[j*DW +: DW] <= DW'(32'hA000 + cyc + j);
  end

  assign tr_out = use_stub ? stub_val : arr_out;

  logic [RW-1:0] tile     [W];
  logic [RW-1:0] exp_rows [W];

  task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int j = 0; j < W; j++) r[j*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic logic [RW-1:0] tile_col(input int k);
    logic [RW-1:0] r;
    for (int j = 0; j < W; j++) r[j*DW +: DW] = tile[j][k*DW +: DW];
    return r;
  endfunction

  task automatic check_out(input int k);
    check_eq("out_valid", bus.out_valid, 1);
    check_eq("out_last", bus.out_last, (k == W - 1) ? 1 : 0);
    check_eq("out_row", bus.out_row, exp_rows[k]);
  endtask

  // Called at a negedge with the DUT in FILL; returns at the negedge after
  // the last read cycle (or right after an aborting reset).
  // gap_pct < 0 means in_valid alternates 1-0-1-0.
  task automatic run_tile(input int gap_pct, input bit stub, input int abort_k,
                          output int first_acc, output int first_ov);
    int  n    = 0;
    int  it   = 0;
    bit  gap;
    first_acc = -1;
    first_ov  = -1;
    use_stub  = stub;
    while (n < W) begin
      check_eq("fill_ready", bus.in_ready, 1);
      check_eq("fill_busy", busy, 0);
      check_eq("fill_mode", tr_mode, 0);
      check_eq("fill_tr_in", tr_in, 0);
      if (it > 0) check_eq("fill_out_valid", bus.out_valid, 0);
      gap = (gap_pct < 0) ? (it % 2 == 1) : ($urandom_range(99) < gap_pct);
      if (gap) begin
        bus.in_valid = 1'b0;
        bus.in_row   = rand_row();
      end else begin
        bus.in_valid = 1'b1;
        bus.in_row   = tile[n];
        if (n == 0) first_acc = cyc;
        n++;
      end
      it++;
      @(negedge clk);
      if (it > 1000) begin
        check_eq("fill_budget", it, 0);
        return;
      end
    end
    for (int c = 0; c < W; c++) begin
      bus.in_valid = 1'($urandom_range(1));
      bus.in_row   = rand_row();
      check_eq("load_mode", tr_mode, 0);
      check_eq("load_tr_in", tr_in, tile[c]);
      check_eq("load_ready", bus.in_ready, 0);
      check_eq("load_busy", busy, 1);
      check_eq("load_out_valid", bus.out_valid, 0);
      @(negedge clk);
    end
    for (int k = 0; k < W; k++) begin
      bus.in_valid = 1'($urandom_range(1));
      bus.in_row   = rand_row();
      if (k > 0) begin
        if (k == 1 && bus.out_valid === 1'b1) first_ov = cyc;
        check_out(k - 1);
      end else begin
        check_eq("read0_out_valid", bus.out_valid, 0);
      end
      check_eq("read_mode", tr_mode, 1);
      check_eq("read_tr_in", tr_in, 0);
      check_eq("read_ready", bus.in_ready, 0);
      check_eq("read_busy", busy, 1);
      if (k == abort_k) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("abort_out_valid", bus.out_valid, 0);
        check_eq("abort_out_last", bus.out_last, 0);
        check_eq("abort_out_row", bus.out_row, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ready", bus.in_ready, 1);
        check_eq("abort_mode", tr_mode, 0);
        return;
      end
      exp_rows[k] = stub ? tr_out : tile_col(k);
      @(negedge clk);
    end
    check_out(W - 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fa, fo, fa2, fo2;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_row   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_last", bus.out_last, 0);
    check_eq("rst_out_row", bus.out_row, 0);
    check_eq("rst_tr_mode", tr_mode, 0);
    check_eq("rst_tr_in", tr_in, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    check_eq("post_rst_ready", bus.in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_ready", bus.in_ready, 1);
      check_eq("idle_out_valid", bus.out_valid, 0);
    end

    // Directed identity-like tile, then a random tile at full rate.
    tile[0] = 64'h0003_0002_0001_0000;
    tile[1] = 64'h0013_0012_0011_0010;
    tile[2] = 64'h0023_0022_0021_0020;
    tile[3] = 64'h0033_0032_0031_0030;
    run_tile(0, 1'b0, -1, fa, fo);
    check_eq("latency", fo - fa, 2 * W + 1);
    for (int r = 0; r < W; r++) tile[r] = rand_row();
    run_tile(0, 1'b0, -1, fa2, fo2);
    check_eq("tile_spacing", fo2 - fo, 3 * W);

    // Stub source with alternating in_valid.
    for (int r = 0; r < W; r++) tile[r] = rand_row();
    run_tile(-1, 1'b1, -1, fa, fo);

    // Reset during read cycle 2, then a clean tile.
    for (int r = 0; r < W; r++) tile[r] = rand_row();
    run_tile(0, 1'b0, 2, fa, fo);
    for (int r = 0; r < W; r++) tile[r] = rand_row();
    run_tile(30, 1'b0, -1, fa, fo);

    // Random tiles: random gaps and tr_out source.
    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < W; r++) tile[r] = rand_row();
      run_tile($urandom_range(60), 1'($urandom_range(1)), -1, fa, fo);
    end

    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("end_out_valid", bus.out_valid, 0);
    check_eq("end_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
